// File: rtl/clock_divider_pkg.sv
// Shared timebase helpers: counter width sizing and reset polarity.
// Imported by the clock divider and the other timebase blocks.
package clock_divider_pkg;

  localparam logic RST_ACTIVE = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_mod_counter.sv
// Generic modulo-N counter with a terminal-count flag.
// Wraps to zero after reaching N-1.
module mod_counter
  import clock_divider_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = clog2_min1(N)
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  // Next count: wrap at terminal count, else increment.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tc_o) cnt_d = '0;
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ACTIVE) cnt_q <= '0;
    else                     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_divider.sv
// 50% duty integer clock divider with a rising-edge strobe.
// clk_o toggles every N input cycles; tick_o marks each rise.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int N     = 50000000,
  parameter int CNT_W = clog2_min1(N)
) (
  input  logic clk_second,
  input  logic rst_i,
  output logic clk_o,
  output logic tick_o
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "clock_divider: N must be >= 1");
  end

  logic tc;
  logic clk_q;
  logic clk_d;
  logic tick_q;
  logic tick_d;

  mod_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (clk_second),
    .rst_i (rst_i),
    .tc_o  (tc)
  );

  // Toggle at terminal count; strobe only when the toggle is a rise.
  always_comb begin
    clk_d  = clk_q ^ tc;
    tick_d = tc & ~clk_q;
  end

  // Output flops, so clk_o and tick_o are glitch-free.
  always_ff @(posedge clk_second or posedge rst_i) begin
    if (rst_i == RST_ACTIVE) begin
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Randomized bench for clock_divider at N = 1, 3, 4, 500.
// Reference: outputs derived from edges counted since reset release.
module tb_clock_divider;

  logic clk_second = 1'b0;
  logic rst_i;
  logic c1, t1, c3, t3, c4, t4, c500, t500;

  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;
  bit run_chk = 1'b0;
  bit p500 = 1'b0;
  int rise_q[$];

  always #5 clk_second = ~clk_second;

  clock_divider #(.N(1)) u_n1 (
    .clk_second (clk_second), .rst_i (rst_i),
    .clk_o (c1), .tick_o (t1));
  clock_divider #(.N(3)) u_n3 (
    .clk_second (clk_second), .rst_i (rst_i),
    .clk_o (c3), .tick_o (t3));
  clock_divider #(.N(4)) u_n4 (
    .clk_second (clk_second), .rst_i (rst_i),
    .clk_o (c4), .tick_o (t4));
  clock_divider #(.N(500)) u_n500 (
    .clk_second (clk_second), .rst_i (rst_i),
    .clk_o (c500), .tick_o (t500));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, want %0d (t=%0t k=%0d)",
                 tag, got, exp, $time, k);
    end
  endtask

  // After k released edges: high in odd N-blocks, tick right after a rise.
  function automatic logic exp_clk(input int n, input int kk);
    return ((kk / n) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int n, input int kk);
    return kk > 0 && (kk % (2 * n)) == n;
  endfunction

  always @(posedge clk_second) begin
    if (rst_i) k = 0;
    else       k = k + 1;
  end

  always @(negedge clk_second) begin
    if (run_chk) begin
      chk("clk_n1",   c1,   rst_i ? 1'b0 : exp_clk(1, k));
      chk("tick_n1",  t1,   rst_i ? 1'b0 : exp_tick(1, k));
      chk("clk_n3",   c3,   rst_i ? 1'b0 : exp_clk(3, k));
      chk("tick_n3",  t3,   rst_i ? 1'b0 : exp_tick(3, k));
      chk("clk_n4",   c4,   rst_i ? 1'b0 : exp_clk(4, k));
      chk("tick_n4",  t4,   rst_i ? 1'b0 : exp_tick(4, k));
      chk("clk_n500", c500, rst_i ? 1'b0 : exp_clk(500, k));
      chk("tick_n500",t500, rst_i ? 1'b0 : exp_tick(500, k));
      if (!rst_i && c500 && !p500) rise_q.push_back(k);
      p500 = c500;
    end
  end

  task automatic async_reset_check(input string tag);
    @(negedge clk_second);
    #($urandom_range(1, 3));
    rst_i = 1'b1;
    #1;
    chk({tag, "_c1"},   c1,   1'b0);
    chk({tag, "_c3"},   c3,   1'b0);
    chk({tag, "_c4"},   c4,   1'b0);
    chk({tag, "_c500"}, c500, 1'b0);
    chk({tag, "_t3"},   t3,   1'b0);
    chk({tag, "_t1"},   t1,   1'b0);
  endtask

  task automatic release_rst();
    @(negedge clk_second);
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    bit found;
    int ncyc;
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    run_chk = 1'b1;
    repeat (10) @(negedge clk_second);

    // Long run from release: covers N=3 ticks and N=500 rise times.
    release_rst();
    rise_q.delete();
    repeat (3000) @(posedge clk_second);
    @(negedge clk_second);
    #1;
    chk("n500_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("n500_rise0", rise_q[0], 500);
      chk("n500_rise1", rise_q[1], 1500);
      chk("n500_rise2", rise_q[2], 2500);
    end

    // Mid-period reset on N=4 when cnt=2 with clk_o high.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_second);
      if (k % 8 == 6) begin
        found = 1'b1;
        break;
      end
    end
    chk("n4_phase_found", found, 1'b1);
    chk("n4_high_before", c4, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("n4_async_drop", c4, 1'b0);
    repeat (3) @(negedge clk_second);
    release_rst();
    repeat (12) @(negedge clk_second);

    // Randomized run lengths and reset pulses.
    for (int it = 0; it < 25; it++) begin
      ncyc = $urandom_range(1, 60);
      repeat (ncyc) @(negedge clk_second);
      async_reset_check("async");
      repeat ($urandom_range(1, 4)) @(negedge clk_second);
      release_rst();
    end
    repeat (40) @(negedge clk_second);

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
# clock_divider

Parameterised integer clock divider. It produces a 50 %-duty divided clock from a fast input clock. The clock/time-keeping logic instantiates it twice: one instance generates the 1 Hz timebase, the other the accelerated timebase used for fast clock setting. It also provides a single-cycle strobe aligned to each divided-clock rising edge, for logic that prefers a clock enable over a derived clock.

## Interface
Parameters:
- N, default 50000000: half-period of clk_o in input clock cycles. Legal range is N ≥ 1. Output period is 2·N input cycles.
- CNT_W, default $clog2(N) (minimum 1): width of the internal counter. Derived from N; callers do not override it.

Ports:
- clk_second  input  1  input clock. All state updates on its rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- clk_o  output  1  divided clock, 50 % duty, period 2·N cycles of clk_second.
- tick_o  output  1  one-cycle pulse, registered, high during the cycle in which clk_o has just risen.

## Operation
- Internal modulo-N counter `cnt` (CNT_W bits) and toggle register `clk_q`. clk_o is driven directly by `clk_q`.
- On each rising edge of clk_second with rst_i low:
  - If cnt == N-1: cnt ← 0 and clk_q ← ~clk_q.
  - Otherwise: cnt ← cnt + 1.
- tick_o ← 1 on an edge where cnt == N-1 and clk_q == 0, i.e. clk_o is rising. On every other edge, tick_o ← 0.
- N == 1: clk_q toggles on every edge, giving period 2 input cycles. tick_o is high every other cycle.
- Arithmetic is unsigned. cnt never exceeds N-1, so no overflow handling is required.
- Elaboration must fail if N < 1 (generate-time error or assertion).
- No glitches: clk_o and tick_o are direct flop outputs, with no combinational gating.

## Timing
- Reset (rst_i high, asynchronous, immediate): cnt = 0, clk_o = 0, tick_o = 0. These are held for as long as rst_i is high.
- Reset release: the first clk_o rise occurs on the N-th rising edge of clk_second after rst_i deasserts. tick_o is high for the cycle that follows that edge.
- Steady state:
  - clk_o is high for exactly N cycles and low for exactly N cycles.
  - tick_o pulses once every 2·N cycles, coincident with clk_o being high in its first cycle.
- Reset mid-period: clk_o returns to 0 and cnt returns to 0 immediately. Any partial period is discarded, and the next rise is again N edges after release.
- Latency from the counter reaching terminal count to the output change is one register stage. There is no combinational path from any input to any output.

## Structure
- Shared package: a `clog2_min1` width helper function and the reset polarity constant. These are reused by other timebase blocks.
- Optional sub-module `mod_counter`: a generic modulo-N counter with a terminal-count flag. clock_divider wraps it with the toggle and tick registers.
- Two instances in the parent: N = 50000000 for the 1 Hz timebase and N = 500 for the accelerated timebase. The parent selects between them.

## Test plan
- Reset hold: N=3, rst_i high for 10 cycles → clk_o = 0, tick_o = 0 throughout. Check also that rst_i asserted asynchronously, between clock edges, forces both outputs low before the next edge.
- Basic division: N=3, release reset → clk_o rises on edge 3, falls on edge 6, rises on edge 9. Measured period is 6 cycles with 3 high and 3 low.
- Tick alignment: N=3, 5 periods → tick_o is exactly 5 single-cycle pulses, each coincident with the first high cycle of clk_o, spaced 6 cycles apart.
- Minimum N: N=1 → clk_o toggles every edge (pattern 0,1,0,1 …). tick_o = 1 on every cycle where clk_o = 1.
- Mid-period reset: N=4, assert rst_i when cnt = 2 with clk_o high → clk_o drops to 0 immediately. After release, the first rise is on the 4th edge.
- Large N sanity: N=500, run 3000 cycles → exactly 3 clk_o rising edges, at cycles 500, 1500 and 2500 after release.
